// File: rtl/ram_access_ctrl.sv
// Load/store initiator for the data RAM: sub-word stores are done as read-modify-write, loads are sign/zero extended.
// One request at a time; req_ready only in IDLE. Optional macro RAM_ACCESS_MISALIGN_ERR_EN rejects misaligned H/W accesses.
module ram_access_ctrl #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_data_input,
  output logic              ram_store,
  output logic              ram_load,
  input  logic [31:0]       ram_data_output
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

`ifdef RAM_ACCESS_MISALIGN_ERR_EN
  localparam bit MISALIGN_ERR = 1'b1;
`else
  localparam bit MISALIGN_ERR = 1'b0;
`endif

  state_t      state;
  logic [1:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  assign req_ready = (state == IDLE);

  function automatic logic bad_req(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    logic misaligned;
    case (f3)
      3'b000, 3'b001, 3'b010: bad = 1'b0;
      3'b100, 3'b101:         bad = we;
      default:                bad = 1'b1;
    endcase
    misaligned = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    return bad || (MISALIGN_ERR && misaligned);
  endfunction

  // Force natural alignment so the lane selects below never straddle a lane boundary.
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return off;
      2'b01:   return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3[1:0])
      2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] wd,
                                        input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    if (f3[1:0] == 2'b00)
      r[{off, 3'b000} +: 8] = wd[7:0];
    else
      r[{off[1], 4'b0000} +: 16] = wd;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 2'd0;
      we_q           <= 1'b0;
      f3_q           <= 3'b000;
      off_q          <= 2'b00;
      wdata_q        <= 16'h0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= 32'h0;
      ram_address    <= '0;
      ram_data_input <= 32'h0;
      ram_store      <= 1'b0;
      ram_load       <= 1'b0;
    end else begin
      ram_load  <= 1'b0;
      ram_store <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            off_q   <= align_off(req_funct3, req_addr[1:0]);
            wdata_q <= req_wdata[15:0];
            if (bad_req(req_we, req_funct3, req_addr[1:0])) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              ram_address <= req_addr[ADDR_W+1:2];
              if (req_we && req_funct3 == 3'b010) begin
                state          <= WR;
                ram_store      <= 1'b1;
                ram_data_input <= req_wdata;
              end else begin
                state    <= RD;
                ram_load <= 1'b1;
              end
            end
          end
        end
        RD: begin
          state <= WAIT;
          cnt   <= 2'd0;
        end
        WAIT: begin
          if (cnt == 2'(RD_LAT - 1)) begin
            if (we_q) begin
              state          <= WR;
              ram_store      <= 1'b1;
              ram_data_input <= merge(ram_data_output, wdata_q, f3_q, off_q);
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= load_ext(ram_data_output, f3_q, off_q);
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        WR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= 32'h0;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed test-plan steps followed by random requests, checked against a byte-addressed memory model.
module tb_ram_access_ctrl;
  localparam int ADDR_W = 12;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_data_input;
  logic              ram_store;
  logic              ram_load;
  logic [31:0]       ram_data_output;

  ram_access_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_address(ram_address), .ram_data_input(ram_data_input),
    .ram_store(ram_store), .ram_load(ram_load), .ram_data_output(ram_data_output)
  );

  always #5 clk = ~clk;

  // RAM with RD_LAT-cycle read latency
  bit [31:0] mem  [0:(1<<ADDR_W)-1];
  bit [31:0] pipe [0:RD_LAT-1];
  assign ram_data_output = pipe[RD_LAT-1];
  always @(posedge clk) begin
    if (ram_store) mem[ram_address] <= ram_data_input;
    if (ram_load) pipe[0] <= mem[ram_address];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Reference: flat byte memory
  bit [7:0] ref_b [0:(1<<(ADDR_W+2))-1];

  int cyc = 0, n_load = 0, n_store = 0, n_both = 0, n_rsp = 0;
  int acc_t[$];
  logic [ADDR_W-1:0] ld_addr, st_addr;
  logic [31:0] st_data;
  always @(posedge clk) begin
    cyc++;
    if (ram_load) begin n_load++; ld_addr = ram_address; end
    if (ram_store) begin n_store++; st_addr = ram_address; st_data = ram_data_input; end
    if (ram_load && ram_store) n_both++;
    if (rsp_valid) n_rsp++;
    if (req_valid && req_ready && !reset) acc_t.push_back(cyc);
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_bad(input bit we, input bit [2:0] f3, input int addr);
    bit legal;
    bit misal;
    int size;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    misal = (addr % size) != 0;
`ifdef RAM_ACCESS_MISALIGN_ERR_EN
    return !legal || misal;
`else
    return !legal;
`endif
  endfunction

  task automatic do_req(input bit we, input bit [2:0] f3, input int addr, input logic [31:0] wd);
    bit bad;
    int size, ea, wa, lat, exp_lat, l0, s0;
    logic [31:0] exp_rd, exp_word;
    bad  = model_bad(we, f3, addr);
    size = 1 << f3[1:0];
    ea   = addr - (addr % size);
    wa   = addr / 4;
    exp_rd = 32'h0;
    exp_word = 32'h0;
    if (bad)                 exp_lat = 1;
    else if (we && size == 4) exp_lat = 2;
    else if (we)             exp_lat = 3 + RD_LAT;
    else                     exp_lat = 2 + RD_LAT;
    if (!bad && !we) begin
      for (int i = 0; i < size; i++) exp_rd = exp_rd | (32'(ref_b[ea+i]) << (8*i));
      if (!f3[2] && size < 4 && exp_rd[8*size-1]) exp_rd = exp_rd | (32'hFFFFFFFF << (8*size));
    end
    if (!bad && we) begin
      for (int i = 0; i < size; i++) ref_b[ea+i] = wd[8*i +: 8];
      exp_word = {ref_b[wa*4+3], ref_b[wa*4+2], ref_b[wa*4+1], ref_b[wa*4]};
    end
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    l0 = n_load;
    s0 = n_store;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = (ADDR_W+2)'(addr); req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = (ADDR_W+2)'($urandom); req_wdata = $urandom;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = k; break; end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (lat != 0) begin
      chk("rsp_err", 32'(rsp_err), 32'(bad));
      chk("rsp_rdata", rsp_rdata, exp_rd);
    end
    chk("load_strobes", 32'(n_load - l0), (!bad && (!we || size < 4)) ? 32'd1 : 32'd0);
    chk("store_strobes", 32'(n_store - s0), (!bad && we) ? 32'd1 : 32'd0);
    if (!bad && we) begin
      chk("store_addr", 32'(st_addr), 32'(wa));
      chk("store_data", st_data, exp_word);
    end
    if (!bad && !we) chk("load_addr", 32'(ld_addr), 32'(wa));
    chk("load_store_overlap", 32'(n_both), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, gap;
    bit [2:0] f3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_ram_store", 32'(ram_store), 32'd0);
    chk("rst_ram_load", 32'(ram_load), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_ram_address", 32'(ram_address), 32'd0);
    chk("rst_ram_data_input", ram_data_input, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_req(1'b1, 3'b010, 'h014, 32'hABCDEF01);
    do_req(1'b0, 3'b010, 'h014, 32'h0);
    do_req(1'b1, 3'b000, 'h016, 32'h00000077);
    do_req(1'b0, 3'b000, 'h017, 32'h0);
    do_req(1'b0, 3'b100, 'h017, 32'h0);
    do_req(1'b0, 3'b001, 'h016, 32'h0);
    do_req(1'b0, 3'b101, 'h016, 32'h0);
    do_req(1'b0, 3'b010, 'h015, 32'h0);
    do_req(1'b0, 3'b011, 'h014, 32'h0);
    do_req(1'b1, 3'b100, 'h014, 32'h0);

    // Reset lands while the SH is in WAIT; the store must be dropped.
    @(negedge clk);
    s0 = n_store;
    r0 = n_rsp;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 'h014; req_wdata = 32'h5555;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_store_now", 32'(ram_store), 32'd0);
    repeat (6) @(negedge clk);
    chk("rst_mid_no_store", 32'(n_store - s0), 32'd0);
    chk("rst_mid_no_rsp", 32'(n_rsp - r0), 32'd0);
    do_req(1'b0, 3'b010, 'h014, 32'h0);

    // req_valid held high: next accept only once IDLE returns
    acc_t.delete();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 'h014;
    repeat (10) @(negedge clk);
    req_valid = 1'b0;
    gap = (acc_t.size() >= 2) ? acc_t[1] - acc_t[0] : 0;
    chk("b2b_gap", 32'(gap), 32'(3 + RD_LAT));
    repeat (8) @(negedge clk);

    for (int n = 0; n < 80; n++) begin
      f3 = 3'($urandom_range(0, 7));
      if (f3 inside {3'd3, 3'd6, 3'd7} && $urandom_range(0, 3) != 0) f3 = 3'd2;
      do_req(1'($urandom), f3, int'($urandom_range(0, 63)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
